// File: rtl/mod_counter_pkg.sv
// Shared types and constants for the modulo-N counter slice.
// Holds the state encoding and the modulus-to-last-value helper.
package mod_counter_pkg;

   localparam int CNT_W = 4;

   // A modulus of zero selects the full 16-value range.
   localparam logic [CNT_W-1:0] MOD_FULL = '0;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   function automatic logic [CNT_W-1:0] last_of(input logic [CNT_W-1:0] modv);
      logic [CNT_W-1:0] one;
      one = {{(CNT_W-1){1'b0}}, 1'b1};
      return (modv == MOD_FULL) ? {CNT_W{1'b1}} : (modv - one);
   endfunction

endpackage

// File: rtl/inc_ripple_4.sv
// 4-bit ripple incrementor: sum = a + 1 with carry out.
// Built as a chain of half-adder cells with the chain carry-in tied high.
module inc_ripple_4
   import mod_counter_pkg::*;
(
   input  logic [CNT_W-1:0] i_a,
   output logic [CNT_W-1:0] o_sum,
   output logic             o_cout
);

   logic [CNT_W:0] w_c;

   assign w_c[0] = 1'b1;

   for (genvar i = 0; i < CNT_W; i++) begin : g_ha
      assign o_sum[i]  = i_a[i] ^ w_c[i];
      assign w_c[i+1]  = i_a[i] & w_c[i];
   end

   assign o_cout = w_c[CNT_W];

endmodule

// File: rtl/mod_counter_4.sv
// 4-bit modulo-N counter with start/stop, one-shot mode and wrap/overflow flags.
// Build option: define MOD_COUNTER_OVF_EN to compile in the sticky ovf flop.
//
// state | meaning
// IDLE  | q held, waiting for start
// RUN   | q advances every cycle
// DONE  | one-shot finished, q held at last value
module mod_counter_4
   import mod_counter_pkg::*;
#(
   parameter logic [CNT_W-1:0] MOD_RST = 4'd10
)
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             stop,
   input  logic             clr,
   input  logic             load,
   input  logic [CNT_W-1:0] d,
   input  logic             mod_we,
   input  logic [CNT_W-1:0] mod_in,
   input  logic             oneshot,
   output logic [CNT_W-1:0] q,
   output logic             busy,
   output logic             done,
   output logic             wrap,
   output logic             ovf
);

   state_t           r_state;
   state_t           w_state_nxt;
   logic [CNT_W-1:0] r_q;
   logic [CNT_W-1:0] w_q_nxt;
   logic [CNT_W-1:0] r_mod;
   logic [CNT_W-1:0] w_last;
   logic [CNT_W-1:0] w_inc;
   logic             w_carry;
   logic             r_oneshot;
   logic             w_oneshot_nxt;
   logic             r_wrap;
   logic             w_wrap_nxt;
   logic             w_count;
   logic             w_ovf_set;

   inc_ripple_4 u_inc (
      .i_a    (r_q),
      .o_sum  (w_inc),
      .o_cout (w_carry)
   );

   assign w_last = last_of(r_mod);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_q_nxt       = r_q;
      w_oneshot_nxt = r_oneshot;
      w_wrap_nxt    = 1'b0;
      w_count       = 1'b0;
      if (clr) begin
         w_state_nxt = IDLE;
         w_q_nxt     = '0;
      end else begin
         if (stop) begin
            w_state_nxt = IDLE;
         end else if (start && (r_state != RUN)) begin
            w_state_nxt   = RUN;
            w_oneshot_nxt = oneshot;
            if (r_state == DONE) begin
               w_q_nxt = '0;
            end
         end else if ((r_state == RUN) && !load) begin
            if (r_q == w_last) begin
               // A one-shot already sitting on its last value just finishes.
               if (r_oneshot) begin
                  w_state_nxt = DONE;
               end else begin
                  w_count    = 1'b1;
                  w_q_nxt    = '0;
                  w_wrap_nxt = 1'b1;
               end
            end else begin
               w_count = 1'b1;
               w_q_nxt = w_inc;
               if (w_carry && !r_oneshot) begin
                  w_wrap_nxt = 1'b1;
               end
               if (r_oneshot && (w_inc == w_last)) begin
                  w_state_nxt = DONE;
               end
            end
         end
         if (load) begin
            w_q_nxt = d;
         end
      end
   end

   assign w_ovf_set = w_count & w_carry;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_q       <= '0;
         r_mod     <= MOD_RST;
         r_oneshot <= 1'b0;
         r_wrap    <= 1'b0;
      end else begin
         r_q       <= w_q_nxt;
         r_oneshot <= w_oneshot_nxt;
         r_wrap    <= w_wrap_nxt;
         if (mod_we) begin
            r_mod <= mod_in;
         end
      end
   end

`ifdef MOD_COUNTER_OVF_EN
   logic r_ovf;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ovf <= 1'b0;
      end else if (clr) begin
         r_ovf <= 1'b0;
      end else if (w_ovf_set) begin
         r_ovf <= 1'b1;
      end
   end

   assign ovf = r_ovf;
`else
   logic w_unused_ovf_set;

   assign w_unused_ovf_set = w_ovf_set;
   assign ovf              = 1'b0;
`endif

   assign q    = r_q;
   assign busy = (r_state == RUN);
   assign done = (r_state == DONE);
   assign wrap = r_wrap;

endmodule

// File: tb/tb_mod_counter_4.sv
// Self-checking bench for mod_counter_4 using an expectation queue.
// Expected ovf follows MOD_COUNTER_OVF_EN.
module tb_mod_counter_4;

`ifdef MOD_COUNTER_OVF_EN
   localparam logic OVF_ON = 1'b1;
`else
   localparam logic OVF_ON = 1'b0;
`endif

   logic       clk     = 1'b0;
   logic       rst_n   = 1'b0;
   logic       start   = 1'b0;
   logic       stop    = 1'b0;
   logic       clr     = 1'b0;
   logic       load    = 1'b0;
   logic [3:0] d       = 4'd0;
   logic       mod_we  = 1'b0;
   logic [3:0] mod_in  = 4'd0;
   logic       oneshot = 1'b0;
   logic [3:0] q;
   logic       busy;
   logic       done;
   logic       wrap;
   logic       ovf;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      string      tag;
      logic [3:0] q;
      logic       busy;
      logic       done;
      logic       wrap;
      logic       ovf;
   } exp_t;

   exp_t sb[$];

   mod_counter_4 #(.MOD_RST(4'd10)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (start),
      .stop    (stop),
      .clr     (clr),
      .load    (load),
      .d       (d),
      .mod_we  (mod_we),
      .mod_in  (mod_in),
      .oneshot (oneshot),
      .q       (q),
      .busy    (busy),
      .done    (done),
      .wrap    (wrap),
      .ovf     (ovf)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int got, input int exp);
      n_tests++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   // Push the expectation, clock once, then pop and compare just after the edge.
   task automatic tick(input string tag, input logic [3:0] eq, input logic eb,
                       input logic ed, input logic ew, input logic eo);
      exp_t e;
      exp_t o;
      e.tag  = tag;
      e.q    = eq;
      e.busy = eb;
      e.done = ed;
      e.wrap = ew;
      e.ovf  = eo & OVF_ON;
      sb.push_back(e);
      @(posedge clk);
      #1;
      o = sb.pop_front();
      chk({o.tag, "_q"},    int'(q),    int'(o.q));
      chk({o.tag, "_busy"}, int'(busy), int'(o.busy));
      chk({o.tag, "_done"}, int'(done), int'(o.done));
      chk({o.tag, "_wrap"}, int'(wrap), int'(o.wrap));
      chk({o.tag, "_ovf"},  int'(ovf),  int'(o.ovf));
      start   = 1'b0;
      stop    = 1'b0;
      clr     = 1'b0;
      load    = 1'b0;
      mod_we  = 1'b0;
      oneshot = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      #3;
      chk("rst_q",    int'(q),    0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_wrap", int'(wrap), 0);
      chk("rst_ovf",  int'(ovf),  0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      tick("idle0", 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);

      // Free-running, reset modulus 10: two full periods.
      start = 1'b1;
      tick("fr_start", 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
      for (int p = 0; p < 2; p++) begin
         for (int i = 1; i <= 10; i++) begin
            tick($sformatf("fr_p%0d_%0d", p, i), 4'(i % 10), 1'b1, 1'b0, (i == 10), 1'b0);
         end
      end
      start = 1'b1;
      tick("fr_start_ign", 4'd1, 1'b1, 1'b0, 1'b0, 1'b0);
      stop = 1'b1;
      tick("fr_stop", 4'd1, 1'b0, 1'b0, 1'b0, 1'b0);
      tick("fr_hold", 4'd1, 1'b0, 1'b0, 1'b0, 1'b0);

      // One-shot, modulus 5.
      clr    = 1'b1;
      mod_we = 1'b1;
      mod_in = 4'd5;
      tick("os_clr", 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      start   = 1'b1;
      oneshot = 1'b1;
      tick("os_start", 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
      for (int i = 1; i <= 3; i++) begin
         tick($sformatf("os_%0d", i), 4'(i), 1'b1, 1'b0, 1'b0, 1'b0);
      end
      tick("os_last", 4'd4, 1'b0, 1'b1, 1'b0, 1'b0);
      tick("os_held", 4'd4, 1'b0, 1'b1, 1'b0, 1'b0);
      start = 1'b1;
      tick("os_restart", 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
      tick("os_rs1", 4'd1, 1'b1, 1'b0, 1'b0, 1'b0);
      stop = 1'b1;
      tick("os_stop", 4'd1, 1'b0, 1'b0, 1'b0, 1'b0);

      // Modulus 16: carry-driven wrap sets ovf, clr clears it.
      clr = 1'b1;
      tick("m16_clr", 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      mod_we = 1'b1;
      mod_in = 4'd0;
      start  = 1'b1;
      tick("m16_start", 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
      for (int i = 1; i <= 15; i++) begin
         tick($sformatf("m16_%0d", i), 4'(i), 1'b1, 1'b0, 1'b0, 1'b0);
      end
      tick("m16_wrap", 4'd0, 1'b1, 1'b0, 1'b1, 1'b1);
      tick("m16_after", 4'd1, 1'b1, 1'b0, 1'b0, 1'b1);
      clr = 1'b1;
      tick("m16_clr2", 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);

      // Modulus 6 with an out-of-range load while running.
      mod_we = 1'b1;
      mod_in = 4'd6;
      start  = 1'b1;
      tick("ld_start", 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
      tick("ld_1", 4'd1, 1'b1, 1'b0, 1'b0, 1'b0);
      load = 1'b1;
      d    = 4'd12;
      tick("ld_12", 4'd12, 1'b1, 1'b0, 1'b0, 1'b0);
      tick("ld_13", 4'd13, 1'b1, 1'b0, 1'b0, 1'b0);
      tick("ld_14", 4'd14, 1'b1, 1'b0, 1'b0, 1'b0);
      tick("ld_15", 4'd15, 1'b1, 1'b0, 1'b0, 1'b0);
      tick("ld_wrap", 4'd0, 1'b1, 1'b0, 1'b1, 1'b1);
      for (int i = 1; i <= 5; i++) begin
         tick($sformatf("ld_run%0d", i), 4'(i), 1'b1, 1'b0, 1'b0, 1'b1);
      end
      tick("ld_modwrap", 4'd0, 1'b1, 1'b0, 1'b1, 1'b1);

      // Command priority.
      clr   = 1'b1;
      load  = 1'b1;
      start = 1'b1;
      d     = 4'd9;
      tick("pri_clr", 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      load  = 1'b1;
      start = 1'b1;
      d     = 4'd3;
      tick("pri_ldst", 4'd3, 1'b1, 1'b0, 1'b0, 1'b0);
      tick("pri_4", 4'd4, 1'b1, 1'b0, 1'b0, 1'b0);
      tick("pri_5", 4'd5, 1'b1, 1'b0, 1'b0, 1'b0);
      tick("pri_wrap", 4'd0, 1'b1, 1'b0, 1'b1, 1'b0);

      // Modulus 1: q pinned at 0, wrap every run cycle.
      stop = 1'b1;
      tick("m1_stop", 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      mod_we = 1'b1;
      mod_in = 4'd1;
      start  = 1'b1;
      tick("m1_start", 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
      tick("m1_a", 4'd0, 1'b1, 1'b0, 1'b1, 1'b0);
      tick("m1_b", 4'd0, 1'b1, 1'b0, 1'b1, 1'b0);
      stop = 1'b1;
      tick("m1_stop2", 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);

      // Asynchronous reset mid-count at q=7; modulus must revert to 10.
      mod_we = 1'b1;
      mod_in = 4'd12;
      start  = 1'b1;
      tick("ar_start", 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
      for (int i = 1; i <= 7; i++) begin
         tick($sformatf("ar_%0d", i), 4'(i), 1'b1, 1'b0, 1'b0, 1'b0);
      end
      #3;
      rst_n = 1'b0;
      #1;
      chk("ar_q",    int'(q),    0);
      chk("ar_busy", int'(busy), 0);
      chk("ar_done", int'(done), 0);
      chk("ar_wrap", int'(wrap), 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      start = 1'b1;
      tick("ar_restart", 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
      for (int i = 1; i <= 10; i++) begin
         tick($sformatf("ar_mod%0d", i), 4'(i % 10), 1'b1, 1'b0, (i == 10), 1'b0);
      end

      chk("sb_empty", sb.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
